// File: rtl/bus_interface.sv
// Host bus front end: turns asynchronous 8-bit host cycles into one-clock 16-bit
// register write strobes, and returns the selected blitter read byte to the host.
module bus_interface #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  output logic        reg_write_strobe_o,
  output logic [3:0]  reg_num_o,
  output logic [15:0] reg_data_o,
  input  logic [15:0] reg_data_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_RELEASE} state_t;

  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [1:0]             settle_q, settle_d;
  logic [7:0]             hi_latch_q, hi_latch_d;
  logic                   rd_active_q, rd_active_d;
  logic                   rd_bs_q, rd_bs_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   strobe_q, strobe_d;
  logic [3:0]             reg_num_q, reg_num_d;
  logic [15:0]            reg_data_q, reg_data_d;
  logic [7:0]             bus_data_q, bus_data_d;
  logic                   cs_act;

  assign cs_act = ~cs_sync_q[SYNC_STAGES-1];

  // The strobe is the only handshake: reg_num_o/reg_data_o are valid in every cycle
  // reg_write_strobe_o is high; the blitter cannot stall, so there is no ready.
  assign reg_write_strobe_o = strobe_q;
  assign reg_num_o          = reg_num_q;
  assign reg_data_o         = reg_data_q;
  assign bus_data_o         = bus_data_q;

  always_comb begin
    state_d     = state_q;
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus_cs_n_i};
    settle_d    = (settle_q == SETTLE) ? settle_q : settle_q + 2'd1;
    hi_latch_d  = hi_latch_q;
    rd_active_d = rd_active_q;
    rd_bs_d     = rd_bs_q;
    wr_pend_d   = 1'b0;
    strobe_d    = wr_pend_q;
    reg_num_d   = reg_num_q;
    reg_data_d  = reg_data_q;
    bus_data_d  = bus_data_q;

    if (rd_active_q) begin
      bus_data_d = rd_bs_q ? reg_data_i[7:0] : reg_data_i[15:8];
    end

    case (state_q)
      // The synchronizer resets to "inactive", so cs_act is only trusted once the
      // chain has been refilled with real pin samples; a held-low cs is then ignored.
      WAIT_RELEASE: begin
        if (settle_q == SETTLE && !cs_act) state_d = IDLE;
      end
      IDLE: begin
        if (cs_act) begin
          state_d = ACTIVE;
          if (bus_rd_nwr_i) begin
            rd_active_d = 1'b1;
            rd_bs_d     = bus_bytesel_i;
          end else if (!bus_bytesel_i) begin
            hi_latch_d = bus_data_i;
          end else begin
            wr_pend_d  = 1'b1;
            reg_num_d  = bus_reg_num_i;
            reg_data_d = {hi_latch_q, bus_data_i};
          end
        end
      end
      ACTIVE: begin
        if (!cs_act) begin
          state_d     = IDLE;
          rd_active_d = 1'b0;
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= WAIT_RELEASE;
      cs_sync_q   <= '1;
      settle_q    <= 2'd0;
      hi_latch_q  <= 8'h00;
      rd_active_q <= 1'b0;
      rd_bs_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      strobe_q    <= 1'b0;
      reg_num_q   <= 4'h0;
      reg_data_q  <= 16'h0000;
      bus_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      settle_q    <= settle_d;
      hi_latch_q  <= hi_latch_d;
      rd_active_q <= rd_active_d;
      rd_bs_q     <= rd_bs_d;
      wr_pend_q   <= wr_pend_d;
      strobe_q    <= strobe_d;
      reg_num_q   <= reg_num_d;
      reg_data_q  <= reg_data_d;
      bus_data_q  <= bus_data_d;
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
// Bench for bus_interface: two instances (SYNC_STAGES 2 and 3) share the host bus;
// a latency/data model predicts every strobe and read byte.
module tb_bus_interface;

  logic        clk;
  logic        reset_i;
  logic        bus_cs_n_i;
  logic        bus_rd_nwr_i;
  logic        bus_bytesel_i;
  logic [3:0]  bus_reg_num_i;
  logic [7:0]  bus_data_i;
  logic [15:0] reg_data_i;

  logic [7:0]  bd2, bd3;
  logic        stb2, stb3;
  logic [3:0]  num2, num3;
  logic [15:0] dat2, dat3;

  bus_interface #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset_i(reset_i), .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i),
    .bus_bytesel_i(bus_bytesel_i), .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i),
    .bus_data_o(bd2), .reg_write_strobe_o(stb2), .reg_num_o(num2), .reg_data_o(dat2),
    .reg_data_i(reg_data_i)
  );

  bus_interface #(.SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .reset_i(reset_i), .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i),
    .bus_bytesel_i(bus_bytesel_i), .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i),
    .bus_data_o(bd3), .reg_write_strobe_o(stb3), .reg_num_o(num3), .reg_data_o(dat3),
    .reg_data_i(reg_data_i)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rd_samp;
  always @(posedge clk) rd_samp <= reg_data_i;

  // ---------------- model state ----------------
  // Strobe entries: {cycle[15:0], reg_num[3:0], data[15:0]}
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];
  logic [7:0]  hi_model = 8'h00;
  logic        reading  = 1'b0;
  logic        rd_bs    = 1'b0;
  int          rd_start[2];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic stb, input logic [3:0] num,
                           input logic [15:0] dat, input logic [7:0] bd);
    logic        have;
    logic [35:0] front;
    logic [7:0]  exp_bd;
    have  = 1'b0;
    front = '0;
    if (k == 0) begin
      if (exp_q0.size() > 0 && exp_q0[0][35:20] == cyc[15:0]) begin
        have = 1'b1;
        front = exp_q0.pop_front();
      end
    end else begin
      if (exp_q1.size() > 0 && exp_q1[0][35:20] == cyc[15:0]) begin
        have = 1'b1;
        front = exp_q1.pop_front();
      end
    end
    tests++;
    if (stb !== have) begin
      fails++;
      $display("FAIL strobe_dut%0d cyc=%0d got %0b expected %0b", k, cyc, stb, have);
    end
    if (have) begin
      tests++;
      if (num !== front[19:16] || dat !== front[15:0]) begin
        fails++;
        $display("FAIL wdata_dut%0d cyc=%0d got %0h/%0h expected %0h/%0h",
                 k, cyc, num, dat, front[19:16], front[15:0]);
      end
    end
    if (reading && cyc >= rd_start[k]) begin
      exp_bd = rd_bs ? rd_samp[7:0] : rd_samp[15:8];
      tests++;
      if (bd !== exp_bd) begin
        fails++;
        $display("FAIL rdata_dut%0d cyc=%0d got %0h expected %0h", k, cyc, bd, exp_bd);
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, stb2, num2, dat2, bd2);
    check_dut(1, stb3, num3, dat3, bd3);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called just after a rising edge; the next edge (E) is the first to see cs_n low.
  // Strobe and first read byte appear SYNC_STAGES+1 clocks after E.
  task automatic start_access(input logic rd, input logic bs, input logic [3:0] rn,
                              input logic [7:0] d);
    int e;
    e = cyc + 1;
    bus_rd_nwr_i  = rd;
    bus_bytesel_i = bs;
    bus_reg_num_i = rn;
    bus_data_i    = d;
    bus_cs_n_i    = 1'b0;
    if (rd) begin
      reading     = 1'b1;
      rd_bs       = bs;
      rd_start[0] = e + 3;
      rd_start[1] = e + 4;
    end else if (!bs) begin
      hi_model = d;
    end else begin
      exp_q0.push_back({16'(e + 3), rn, hi_model, d});
      exp_q1.push_back({16'(e + 4), rn, hi_model, d});
    end
  endtask

  task automatic end_access(input int high);
    bus_cs_n_i = 1'b1;
    reading    = 1'b0;
    wait_clks(high);
  endtask

  task automatic access(input logic rd, input logic bs, input logic [3:0] rn,
                        input logic [7:0] d, input int low, input int high);
    start_access(rd, bs, rn, d);
    wait_clks(low);
    end_access(high);
  endtask

  task automatic odd_write_chk(input logic [3:0] rn, input logic [7:0] d,
                               input logic [15:0] exp);
    start_access(1'b0, 1'b1, rn, d);
    wait_clks(4);
    @(negedge clk);
    chk("lit_stb_s2", 32'(stb2), 32'h1);
    chk("lit_data_s2", 32'(dat2), 32'(exp));
    chk("lit_num_s2", 32'(num2), 32'(rn));
    wait_clks(1);
    @(negedge clk);
    chk("lit_stb_s3", 32'(stb3), 32'h1);
    chk("lit_data_s3", 32'(dat3), 32'(exp));
    wait_clks(1);
    end_access(5);
  endtask

  task automatic assert_reset();
    reset_i = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    hi_model = 8'h00;
    reading  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb2"}, 32'(stb2), 32'h0);
    chk({tag, "_stb3"}, 32'(stb3), 32'h0);
    chk({tag, "_num2"}, 32'(num2), 32'h0);
    chk({tag, "_dat2"}, 32'(dat2), 32'h0);
    chk({tag, "_dat3"}, 32'(dat3), 32'h0);
    chk({tag, "_bd2"}, 32'(bd2), 32'h0);
    chk({tag, "_bd3"}, 32'(bd3), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_rd_nwr_i  = 1'b0;
    bus_bytesel_i = 1'b1;
    bus_reg_num_i = 4'h9;
    bus_data_i    = 8'h99;
    reg_data_i    = 16'h0000;
    bus_cs_n_i    = 1'b0;
    assert_reset();

    // cs_n held low through reset release must not start an access
    wait_clks(3);
    @(negedge clk);
    chk_all_zero("reset");
    wait_clks(1);
    reset_i = 1'b0;
    wait_clks(10);
    end_access(5);

    // odd-only writes use the reset hi_latch, which then persists
    odd_write_chk(4'h1, 8'h41, 16'h0041);
    odd_write_chk(4'h1, 8'h42, 16'h0042);

    // even then odd write: one strobe, only on the odd half
    access(1'b0, 1'b0, 4'h2, 8'h1F, 6, 5);
    odd_write_chk(4'h2, 8'h20, 16'h1F20);

    // byte reads, including a blitter update mid-read
    reg_data_i = 16'hE3A5;
    start_access(1'b1, 1'b0, 4'h3, 8'h00);
    wait_clks(5);
    @(negedge clk);
    chk("lit_rd_even_s2", 32'(bd2), 32'hE3);
    chk("lit_rd_even_s3", 32'(bd3), 32'hE3);
    wait_clks(3);
    end_access(5);

    start_access(1'b1, 1'b1, 4'h3, 8'h00);
    wait_clks(5);
    reg_data_i = 16'h1234;
    @(negedge clk);
    chk("lit_rd_odd_s2", 32'(bd2), 32'hA5);
    wait_clks(1);
    @(negedge clk);
    chk("lit_rd_upd_s2", 32'(bd2), 32'h34);
    chk("lit_rd_upd_s3", 32'(bd3), 32'h34);
    wait_clks(2);
    end_access(5);

    // long hold: still exactly one strobe
    access(1'b0, 1'b1, 4'h4, 8'h5A, 50, 5);

    // reset one clock after capture: no strobe, outputs cleared, hi_latch cleared
    start_access(1'b0, 1'b1, 4'h5, 8'h77);
    wait_clks(3);
    assert_reset();
    @(negedge clk);
    chk_all_zero("midreset");
    wait_clks(1);
    reset_i = 1'b0;
    wait_clks(8);
    end_access(5);
    odd_write_chk(4'h3, 8'h66, 16'h0066);

    // back-to-back odd writes at minimum spacing for SYNC_STAGES=3
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b1, 4'(8 + i), 8'(8'hC0 + i), 5, 4);
    end
    wait_clks(10);
    chk("drain_q0", 32'(exp_q0.size()), 32'h0);
    chk("drain_q1", 32'(exp_q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_interface.md
# bus_interface

Host-side register front end for the blitter. Converts asynchronous 8-bit host bus cycles into the blitter's single-cycle 16-bit register write strobe, and returns blitter register read data one byte at a time. It sits between the board-level host bus pins and the blitter's `reg_write_strobe_i` / `reg_num_i` / `reg_data_i` / `reg_data_o` port group.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `bus_cs_n_i` synchronizer. Legal values are 2 or 3.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `bus_cs_n_i`  in  1  host chip select, active-low. Asynchronous to `clk`.
- `bus_rd_nwr_i`  in  1  1 = host read, 0 = host write.
- `bus_bytesel_i`  in  1  0 = even (high) byte [15:8], 1 = odd (low) byte [7:0].
- `bus_reg_num_i`  in  4  register number.
- `bus_data_i`  in  8  host write byte.
- `bus_data_o`  out  8  host read byte (registered).
- `reg_write_strobe_o`  out  1  one-clock write pulse to the blitter.
- `reg_num_o`  out  4  register number; valid whenever the strobe is high.
- `reg_data_o`  out  16  write word; valid whenever the strobe is high.
- `reg_data_i`  in  16  blitter register read word.

## Operation
- Only `bus_cs_n_i` is synchronized. It passes through `SYNC_STAGES` flops, and all flops reset to 1 (inactive). `cs_act` is the inverted output of the last stage.
- All other bus inputs are captured directly when an access starts. The host guarantees:
  - these inputs are stable from the cs_n falling edge until cs_n rises;
  - cs_n stays low at least `SYNC_STAGES`+2 clocks;
  - cs_n stays high at least `SYNC_STAGES`+1 clocks.
- FSM states are IDLE, ACTIVE and WAIT_RELEASE. The reset state is WAIT_RELEASE.
- WAIT_RELEASE: when `cs_act`==0, go to IDLE. This means a cs held low through reset release is ignored rather than treated as a new access.
- IDLE: when `cs_act`==1, capture `bus_rd_nwr_i`, `bus_bytesel_i`, `bus_reg_num_i` and `bus_data_i`, then go to ACTIVE. In that same cycle:
  - **write, bytesel=0:** `hi_latch` <= `bus_data_i`. No strobe.
  - **write, bytesel=1:** next cycle `reg_write_strobe_o`=1, `reg_num_o`=captured reg num, `reg_data_o`={`hi_latch`, `bus_data_i`}.
  - **read:** set `rd_active`=1 and latch bytesel.
- ACTIVE: when `cs_act`==0, go to IDLE and clear `rd_active`.
- `hi_latch` resets to 8'h00 and persists across accesses and register numbers. An odd write with no preceding even write uses the current `hi_latch` value. Reads never modify `hi_latch`.
- While `rd_active`==1, every clock `bus_data_o` <= latched bytesel ? `reg_data_i[7:0]` : `reg_data_i[15:8]`. This tracks late updates from the blitter. Otherwise `bus_data_o` holds its value.
- `reg_num_o` and `reg_data_o` update only on odd-write capture and hold otherwise.
- Reset values: `bus_data_o`=8'h00, `reg_write_strobe_o`=0, `reg_num_o`=4'h0, `reg_data_o`=16'h0000.

## Timing
- Edge E is the first `clk` rising edge that samples `bus_cs_n_i` low.
- `cs_act` rises `SYNC_STAGES`-1 clocks after E. Capture happens on the next edge. `reg_write_strobe_o` is high for exactly one clock, starting `SYNC_STAGES`+1 clocks after E (3 clocks with the default).
- Each access produces at most one strobe, however long cs_n stays low.
- First valid `bus_data_o` appears one clock after capture, i.e. `SYNC_STAGES`+1 clocks after E.
- A cs_n glitch shorter than one clock may be missed entirely. If it is seen, it is treated as a full access; this is acceptable.
- Reset asserted mid-access clears the strobe and outputs immediately (asynchronously). The FSM returns to WAIT_RELEASE, so no strobe is issued for the interrupted access.
- Back-to-back accesses separated by the minimum high time each produce exactly one capture.

## Test plan
- **Even+odd write:** reg 2, even 8'h1F then odd 8'h20 -> exactly one strobe, 3 clocks after the odd cs_n fall, with `reg_num_o`=4'h2 and `reg_data_o`=16'h1F20. The even write alone produces no strobe.
- **Odd-only write:** odd write 8'h41 to reg 1 after reset -> `reg_data_o`=16'h0041. A second odd write 8'h42 -> 16'h0042, proving `hi_latch` persists.
- **Byte reads:** `reg_data_i`=16'hE3A5; read even -> `bus_data_o`=8'hE3, read odd -> 8'hA5. Change `reg_data_i` to 16'h1234 mid-read (odd) -> `bus_data_o` becomes 8'h34 one clock later.
- **Long hold:** odd write with cs_n held low 50 clocks -> exactly one strobe.
- **Reset interactions:** cs_n low while `reset_i` deasserts -> no strobe until cs_n goes high then low again. Reset pulse one clock after capture -> strobe never asserts and all outputs are zero.
- **Back-to-back timing:** repeat odd writes at minimum spacing with both `SYNC_STAGES`=2 and 3 -> one strobe per access, with latency of 3 and 4 clocks respectively.
